// File: rtl/seg_scan_ctrl_if.sv
// Value handshake and multiplexed digit bus of the speed display readout.
// The controller sits on the slave side; the value source and display driver use master.
interface seg_scan_ctrl_if;
  logic [7:0] value_i;
  logic       valid_i;
  logic       ready_o;
  logic [3:0] digit_o;
  logic       sel_o;
  logic       blank_o;
  logic       ovf_o;

  modport slave (
    input  value_i, valid_i,
    output ready_o, digit_o, sel_o, blank_o, ovf_o
  );

  modport master (
    output value_i, valid_i,
    input  ready_o, digit_o, sel_o, blank_o, ovf_o
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Two-digit decimal readout sequencer: saturating capture, 8-cycle double-dabble,
// atomic commit to display registers, and a free-running tens/ones scan with blanking.
module seg_scan_ctrl #(
  parameter int REFRESH_DIV  = 1024,
  parameter int BLANK_CYCLES = 16,
  parameter int LZ_SUPPRESS  = 1
) (
  input  logic           clk_i,
  input  logic           reset_i,
  seg_scan_ctrl_if.slave bus
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

  state_t        state_q, state_d;
  logic [2:0]    iter_q;
  logic [15:0]   work_q;        // {tens, ones, bin}
  logic [15:0]   work_adj;
  logic          ovf_pend_q;
  logic          ovf_q;
  logic [3:0]    tens_q, ones_q, digit_q;
  logic [CW-1:0] scan_q;
  logic          sel_q, sel_d, wrap;
  logic          accept, over;
  logic [7:0]    sat_val;

  assign accept  = bus.valid_i && (state_q == IDLE);
  assign over    = bus.value_i > 8'd99;
  assign sat_val = over ? 8'd99 : bus.value_i;

  // ---------------- FSM ----------------
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = CONVERT;
      CONVERT: if (iter_q == 3'd7) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Add-3 correction on both BCD nibbles before each shift
  always_comb begin
    work_adj = work_q;
    if (work_q[15:12] >= 4'd5) work_adj[15:12] = work_q[15:12] + 4'd3;
    if (work_q[11:8]  >= 4'd5) work_adj[11:8]  = work_q[11:8]  + 4'd3;
  end

  // ---------------- conversion datapath ----------------
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      iter_q     <= '0;
      work_q     <= '0;
      ovf_pend_q <= 1'b0;
      tens_q     <= '0;
      ones_q     <= '0;
      ovf_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          iter_q     <= '0;
          work_q     <= {8'h00, sat_val};
          ovf_pend_q <= over;
        end
        CONVERT: begin
          work_q <= {work_adj[14:0], 1'b0};
          iter_q <= iter_q + 3'd1;
        end
        // Digits and overflow flag move together so the display never tears
        COMMIT: begin
          tens_q <= work_q[15:12];
          ones_q <= work_q[11:8];
          ovf_q  <= ovf_pend_q;
        end
        default: ;
      endcase
    end
  end

  // ---------------- scan / digit mux ----------------
  assign wrap  = (scan_q == CW'(REFRESH_DIV - 1));
  assign sel_d = wrap ? ~sel_q : sel_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      scan_q  <= '0;
      sel_q   <= 1'b0;
      digit_q <= '0;
    end else begin
      scan_q  <= wrap ? '0 : scan_q + CW'(1);
      sel_q   <= sel_d;
      digit_q <= sel_d ? ones_q : tens_q;
    end
  end

  assign bus.ready_o = (state_q == IDLE);
  assign bus.digit_o = digit_q;
  assign bus.sel_o   = sel_q;
  assign bus.ovf_o   = ovf_q;
  assign bus.blank_o = (scan_q < CW'(BLANK_CYCLES)) ||
                       ((LZ_SUPPRESS != 0) && !sel_q && (tens_q == 4'd0));

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Sequencing controller for the two-digit decimal readout of the speed display.
- Accepts an 8-bit binary value over a valid/ready handshake and converts it to two BCD digits with a multi-cycle shift-add-3 (double-dabble) engine.
- Holds the result in display registers and time-multiplexes the digits onto one 4-bit bus with a digit-select line, matching the digit selector's sel convention (0 = tens, 1 = ones).
- Inserts blanking around each digit switch and optionally suppresses a leading zero.

Parameters:
- REFRESH_DIV, 1024: clock cycles per digit phase; legal minimum 2.
- BLANK_CYCLES, 16: cycles at the start of each phase with blank_o forced high; must be < REFRESH_DIV.
- LZ_SUPPRESS, 1: 1 = blank the tens digit when it is 0.

Ports:
- clk_i  input  1  system clock; the single clock domain.
- reset_i  input  1  asynchronous, active-high reset.
- value_i  input  8  binary value to display, unsigned.
- valid_i  input  1  value_i is valid.
- ready_o  output  1  controller can accept a value.
- digit_o  output  4  BCD digit for the currently selected position.
- sel_o  output  1  digit select: 0 = tens, 1 = ones.
- blank_o  output  1  1 = display driver must turn segments off.
- ovf_o  output  1  1 = the last committed value was saturated.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - FSM goes to IDLE; display tens/ones registers = 0.
  - ready_o=1, sel_o=0, ovf_o=0, digit_o=0, blank_o=1 (scan counter 0 lies in the blank window).
  - Reset mid-CONVERT aborts the conversion; no partial result is ever committed.
- Handshake:
  - A transfer occurs on a rising edge where valid_i && ready_o.
  - ready_o=1 only in IDLE.
  - valid_i while ready_o=0 is not consumed; the source holds value_i.
- Capture:
  - If value_i > 99, the working value is 99 and the ovf flag is pending set; otherwise the working value is value_i and the flag is pending clear.
- FSM states:
  - IDLE: on handshake go to CONVERT and clear the iteration counter.
  - CONVERT: exactly 8 cycles. Each cycle: every BCD nibble >= 5 gets +3, then the 16-bit {tens, ones, bin} register shifts left by 1. After iteration 8 go to COMMIT.
  - COMMIT: one cycle. The tens, ones and ovf_o registers update together (no tearing), then return to IDLE.
- Latency:
  - Handshake at edge N.
  - CONVERT occupies cycles N+1..N+8; COMMIT is cycle N+9.
  - New digits and ovf_o are visible from cycle N+10; ready_o is high again at N+10.
  - Back-to-back accept period = 10 cycles.
- Scan counter:
  - Free-running 0..REFRESH_DIV-1, independent of the FSM.
  - On wrap to 0, sel_o toggles.
  - blank_o=1 while counter < BLANK_CYCLES.
  - blank_o is also 1 for the whole sel_o=0 phase when LZ_SUPPRESS=1 and tens==0.
- Digit output:
  - digit_o = tens when sel_o=0, ones when sel_o=1; registered, updating on the same edge as sel_o.
  - digit_o keeps its value during blanking; blank_o alone gates the display.
- Simultaneous events:
  - A COMMIT landing inside a non-blank phase changes digit_o on the following cycle. This is accepted; no wait for a phase boundary.
  - A scan wrap in the same cycle as COMMIT uses the newly committed values from the next cycle onward.
- Arithmetic: all unsigned, no signed interpretation; the BCD nibbles never exceed 9.

Test Plan:
- Reset: assert reset_i asynchronously mid-phase -> outputs go immediately to ready_o=1, sel_o=0, blank_o=1, digit_o=0, ovf_o=0.
- Basic conversion: value_i=0x19 handshake at edge N -> ready_o low N+1..N+9; from N+10 digit_o=2 when sel_o=0 and 5 when sel_o=1; ovf_o=0.
- Saturation: value_i=0xC8 (200) -> digits 9/9, ovf_o=1. Then value_i=0x07 -> ovf_o=0, tens suppressed (blank_o=1 for the whole sel_o=0 phase), ones=7.
- Scan timing: REFRESH_DIV=8, BLANK_CYCLES=2 -> sel_o toggles every 8 cycles; blank_o high for exactly 2 cycles after each toggle. Value 0x63 shows 9 then 9.
- Handshake and back-pressure: hold valid_i with 0x2A during CONVERT -> not consumed until ready_o returns; the next transfer starts exactly 10 cycles after the first; display shows 4/2.
- Reset mid-conversion: assert reset_i at CONVERT iteration 4 with 0x55 in flight -> display stays 0/0; a new 0x55 after release shows 8/5.
